uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver pairing with uart_tx: 8N1-style frames, LSB first, idle-high line.
//  Synchronises rxIn, validates start bit, samples each bit mid-cell, checks stop bit(s).
//  Buffers received words in an output FIFO with a valid/ready pop interface for the flight-controller core.
// PARAMETERS
//  CLKS_PER_BIT        139  clock cycles per bit cell (must match uart_tx); >= 4
//  WORDBITS            8    data bits per frame (1..8)
//  STOPBITS            1    stop bits per frame (1 or 2)
//  OUTPUT_BUFFER_DEPTH 16   FIFO entries; power of two
// PORTS
//  clock       in   1         system clock
//  reset       in   1         asynchronous, active-high reset
//  rxIn        in   1         serial line, asynchronous to clock
//  rxData      out  WORDBITS  FIFO head word, valid when rxValid=1
//  rxValid     out  1         FIFO non-empty
//  rxReady     in   1         consumer pop; pop occurs on clock edge with rxValid&rxReady
//  frameError  out  1         1-cycle pulse: stop bit sampled 0
//  overflow    out  1         1-cycle pulse: word dropped, FIFO full
//  busy        out  1         1 while state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, rxValid=0, rxData=0, frameError=0, overflow=0, busy=0; sync flops=1.
//  rxIn passes through 2-flop synchroniser; all decisions use synchronised bit rx_s.
//  IDLE: on rx_s=0 -> START, timer=0.
//  START: count to CLKS_PER_BIT/2-1 (integer div), then sample: 0 -> DATA, timer=0, bitIdx=0;
//    1 -> IDLE (glitch rejected, nothing pushed, no error).
//  DATA: every CLKS_PER_BIT cycles sample rx_s into shift[bitIdx] (LSB first); after
//    bit WORDBITS-1 -> STOP, timer=0, stopIdx=0.
//  STOP: every CLKS_PER_BIT cycles sample. 0 -> frameError pulse, word discarded, -> BREAK.
//    1 and stopIdx<STOPBITS-1 -> next stop bit. 1 and last -> push word, -> IDLE immediately
//    (mid-stop-bit), allowing back-to-back frames with zero idle.
//  BREAK: wait for rx_s=1, then IDLE (long low line never yields spurious frames).
//  Push: word written on the same edge as the final stop sample; rxValid high next cycle.
//  FIFO is first-word-fall-through: rxData = mem[rd_ptr], rxValid = (count!=0), both registered-state derived.
//  Full and push with no pop: word dropped, overflow pulse, FIFO contents unchanged.
//  Full and push with pop same cycle: pop and push both performed; no overflow.
//  Empty and rxReady=1: no effect. Pointers wrap modulo depth; count is $clog2(depth)+1 bits.
//  Reset mid-frame: frame abandoned, FIFO cleared, no pulses.
//  Timer width $clog2(CLKS_PER_BIT); bitIdx width $clog2(WORDBITS)+1; no arithmetic overflow.
// STRUCTURE
//  uart_pkg: state encodings (IDLE, START, DATA, STOP, BREAK) and framing constants shared with uart_tx.
//  Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count, async active-high reset);
//  reusable for a later uart_tx input-buffer rework.
//  uart_rx top: synchroniser, bit-timer, receive FSM, sync_fifo instance.
// TESTING (bench CLKS_PER_BIT=16, drive rxIn from bit-accurate model)
//  Frame 0xA5, rxReady=1 -> rxValid for 1 cycle, rxData=0xA5, no frameError/overflow.
//  Low glitch 5 cycles on idle line -> busy returns 0, rxValid stays 0, no pulses.
//  Frame 0x3C with stop bit 0, then line high -> frameError 1 pulse, FIFO empty, next 0x55 received.
//  17 frames 0x00..0x10, rxReady=0 -> 16 stored, overflow pulse on 17th; pops yield 0x00..0x0F.
//  Loopback from uart_tx, 4 back-to-back bytes 0x01,0x80,0xFF,0x7E -> received in order, no errors.
//  reset asserted mid DATA of 0x99 -> outputs zero, FIFO empty; following 0x42 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path (and its uart_tx peer):
//   receive FSM state encodings, line levels of the 8N1-style framing, and
//   the mid-bit sampling point helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Last timer value of the half-cell wait in START (integer division),
    // so the start bit is re-checked at its midpoint.
    function automatic int half_bit_last(input int clks_per_bit);
        return (clks_per_bit / 2) - 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. head_data always shows
//   mem[rd_ptr]; a push into a full FIFO is dropped (overflow pulse the
//   following cycle) unless a pop happens on the same edge.
// Ports
//   clock, reset         clock, asynchronous active-high reset
//   push, push_data      write request and word
//   pop                  read request (ignored when empty)
//   head_data            oldest stored word
//   full, empty, count   occupancy status
//   overflow             registered 1-cycle pulse when a push was dropped
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16    // power of two, >= 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;

    logic             pop_ok_s;
    logic             push_ok_s;
    logic             drop_s;
    logic [CW-1:0]    count_n;

    assign pop_ok_s  = pop && (count_r != '0);
    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    assign push_ok_s = push && ((count_r != COUNT_FULL) || pop_ok_s);
    assign drop_s    = push && !push_ok_s;

    // Occupancy update from the accepted push/pop combination.
    always_comb begin
        count_n = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_n = count_r + CW'(1);
            2'b01:   count_n = count_r - CW'(1);
            default: count_n = count_r;
        endcase
    end

    // Storage, pointers, occupancy and overflow pulse register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_n;
            overflow_r <= drop_s;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign full      = (count_r == COUNT_FULL);
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign overflow  = overflow_r;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   Asynchronous serial receiver (idle-high line, LSB first, WORDBITS data
//   bits, STOPBITS stop bits). rxIn is double-flopped, the start bit is
//   re-checked at mid-cell, each data/stop bit is sampled mid-cell, and good
//   words are queued in a sync_fifo with a valid/ready pop interface.
// Ports
//   clock, reset   system clock, asynchronous active-high reset
//   rxIn           serial line (asynchronous to clock)
//   rxData         FIFO head word, valid while rxValid=1
//   rxValid        FIFO non-empty
//   rxReady        consumer pop strobe (pop on rxValid & rxReady)
//   frameError     1-cycle pulse: a stop bit was sampled low
//   overflow       1-cycle pulse: received word dropped, FIFO full
//   busy           receiver is inside a frame (state != IDLE)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT        = 139,
    parameter int WORDBITS            = 8,
    parameter int STOPBITS            = 1,
    parameter int OUTPUT_BUFFER_DEPTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rxIn,
    output logic [WORDBITS-1:0] rxData,
    output logic                rxValid,
    input  logic                rxReady,
    output logic                frameError,
    output logic                overflow,
    output logic                busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WORDBITS) + 1;
    localparam int IW = (WORDBITS > 1) ? $clog2(WORDBITS) : 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(half_bit_last(CLKS_PER_BIT));
    localparam logic [BW-1:0] WORD_LAST = BW'(WORDBITS - 1);
    localparam logic          STOP_LAST = 1'(STOPBITS - 1);

    logic [1:0]          sync_r;
    logic                rx_s;

    uart_state_t         state_r,    state_n;
    logic [TW-1:0]       timer_r,    timer_n;
    logic [BW-1:0]       bit_idx_r,  bit_idx_n;
    logic                stop_idx_r, stop_idx_n;
    logic [WORDBITS-1:0] shift_r,    shift_n;
    logic                push_s;
    logic                frame_err_s;
    logic                frame_err_r;

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [$clog2(OUTPUT_BUFFER_DEPTH):0] fifo_count_s;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r <= {LINE_IDLE, LINE_IDLE};
        end else begin
            sync_r <= {sync_r[0], rxIn};
        end
    end

    assign rx_s = sync_r[1];

    // Receive FSM next-state, bit timer, data shift and push/error strobes.
    always_comb begin
        state_n     = state_r;
        timer_n     = timer_r;
        bit_idx_n   = bit_idx_r;
        stop_idx_n  = stop_idx_r;
        shift_n     = shift_r;
        push_s      = 1'b0;
        frame_err_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (rx_s == START_LEVEL) begin
                    state_n = ST_START;
                    timer_n = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_START: begin
                if (timer_r == HALF_LAST) begin
                    timer_n = '0;
                    if (rx_s == START_LEVEL) begin
                        state_n   = ST_DATA;
                        bit_idx_n = '0;
                    end else begin
                        // Line went back high before mid-cell: treat as a glitch.
                        state_n = ST_IDLE;
                    end
                end else begin
                    timer_n = timer_r + TW'(1);
                end
            end

            ST_DATA: begin
                if (timer_r == BIT_LAST) begin
                    timer_n                  = '0;
                    shift_n[bit_idx_r[IW-1:0]] = rx_s;
                    if (bit_idx_r == WORD_LAST) begin
                        state_n    = ST_STOP;
                        stop_idx_n = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx_r + BW'(1);
                    end
                end else begin
                    timer_n = timer_r + TW'(1);
                end
            end

            ST_STOP: begin
                if (timer_r == BIT_LAST) begin
                    timer_n = '0;
                    if (rx_s == STOP_LEVEL) begin
                        if (stop_idx_r == STOP_LAST) begin
                            // Leave mid-stop-bit so a start bit right after it is caught.
                            push_s  = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            stop_idx_n = 1'b1;
                        end
                    end else begin
                        frame_err_s = 1'b1;
                        state_n     = ST_BREAK;
                    end
                end else begin
                    timer_n = timer_r + TW'(1);
                end
            end

            ST_BREAK: begin
                // Hold off until the line returns high so a long low never frames.
                if (rx_s == LINE_IDLE) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_BREAK;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Receive FSM and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            timer_r     <= '0;
            bit_idx_r   <= '0;
            stop_idx_r  <= 1'b0;
            shift_r     <= '0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            timer_r     <= timer_n;
            bit_idx_r   <= bit_idx_n;
            stop_idx_r  <= stop_idx_n;
            shift_r     <= shift_n;
            frame_err_r <= frame_err_s;
        end
    end

    // Word is presented on the same edge as the final stop sample.
    sync_fifo #(
        .WIDTH (WORDBITS),
        .DEPTH (OUTPUT_BUFFER_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (shift_n),
        .pop       (rxReady),
        .head_data (rxData),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .overflow  (overflow)
    );

    assign rxValid    = !fifo_empty_s;
    assign frameError = frame_err_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Directed bench for uart_rx at 16 clocks per bit. A bit-accurate line
//   driver produces frames; a negedge monitor records popped words and
//   counts rxValid cycles and error pulses; checks compare those against
//   hand-derived expectations.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clock;
    logic       reset;
    logic       rxIn;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic       frameError;
    logic       overflow;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] popped[$];
    int fe_cnt    = 0;
    int ovf_cnt   = 0;
    int valid_cyc = 0;

    uart_rx #(
        .CLKS_PER_BIT        (CPB),
        .WORDBITS            (8),
        .STOPBITS            (1),
        .OUTPUT_BUFFER_DEPTH (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rxIn       (rxIn),
        .rxData     (rxData),
        .rxValid    (rxValid),
        .rxReady    (rxReady),
        .frameError (frameError),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (rxValid && rxReady) popped.push_back(rxData);
        if (rxValid)    valid_cyc = valid_cyc + 1;
        if (frameError) fe_cnt    = fe_cnt + 1;
        if (overflow)   ovf_cnt   = ovf_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: start bit, 8 data bits LSB first, one stop bit of the given level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rxIn = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxIn = d[i];
            tick(CPB);
        end
        rxIn = stop_bit;
        tick(CPB);
        rxIn = 1'b1;
    endtask

    int q0, fe0, ovf0, v0;
    logic [7:0] lb [4];

    initial begin
        reset   = 1'b1;
        rxIn    = 1'b1;
        rxReady = 1'b0;
        tick(3);

        // Reset state
        chk("reset_rxValid",    {31'd0, rxValid},    32'd0);
        chk("reset_rxData",     {24'd0, rxData},     32'd0);
        chk("reset_frameError", {31'd0, frameError}, 32'd0);
        chk("reset_overflow",   {31'd0, overflow},   32'd0);
        chk("reset_busy",       {31'd0, busy},       32'd0);
        reset = 1'b0;
        tick(5);

        // Single frame 0xA5 with consumer ready
        rxReady = 1'b1;
        q0 = popped.size(); fe0 = fe_cnt; ovf0 = ovf_cnt; v0 = valid_cyc;
        send_frame(8'hA5, 1'b1);
        tick(40);
        chk("a5_count",      popped.size() - q0, 32'd1);
        chk("a5_data",       {24'd0, popped[q0]}, 32'h0000_00A5);
        chk("a5_valid_cyc",  valid_cyc - v0,     32'd1);
        chk("a5_frameError", fe_cnt - fe0,       32'd0);
        chk("a5_overflow",   ovf_cnt - ovf0,     32'd0);

        // 5-cycle low glitch on an idle line
        q0 = popped.size(); fe0 = fe_cnt; ovf0 = ovf_cnt; v0 = valid_cyc;
        rxIn = 1'b0;
        tick(5);
        rxIn = 1'b1;
        tick(40);
        chk("glitch_busy",       {31'd0, busy},      32'd0);
        chk("glitch_valid_cyc",  valid_cyc - v0,     32'd0);
        chk("glitch_count",      popped.size() - q0, 32'd0);
        chk("glitch_frameError", fe_cnt - fe0,       32'd0);
        chk("glitch_overflow",   ovf_cnt - ovf0,     32'd0);

        // 0x3C with a low stop bit, then a good 0x55
        q0 = popped.size(); fe0 = fe_cnt; v0 = valid_cyc;
        send_frame(8'h3C, 1'b0);
        tick(40);
        chk("ferr_pulses",    fe_cnt - fe0,       32'd1);
        chk("ferr_valid_cyc", valid_cyc - v0,     32'd0);
        chk("ferr_count",     popped.size() - q0, 32'd0);
        chk("ferr_busy",      {31'd0, busy},      32'd0);
        send_frame(8'h55, 1'b1);
        tick(40);
        chk("after_ferr_count", popped.size() - q0, 32'd1);
        chk("after_ferr_data",  {24'd0, popped[q0]}, 32'h0000_0055);

        // 17 frames into a 16-deep FIFO with no consumer
        rxReady = 1'b0;
        fe0 = fe_cnt; ovf0 = ovf_cnt;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            tick(20);
        end
        chk("ovf_pulses",     ovf_cnt - ovf0,   32'd1);
        chk("ovf_frameError", fe_cnt - fe0,     32'd0);
        chk("ovf_rxValid",    {31'd0, rxValid}, 32'd1);
        chk("ovf_head",       {24'd0, rxData},  32'd0);
        q0 = popped.size();
        rxReady = 1'b1;
        tick(30);
        chk("ovf_drain_count", popped.size() - q0, 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_word%0d", i), {24'd0, popped[q0 + i]}, 32'(i));
        end
        chk("ovf_drained_valid", {31'd0, rxValid}, 32'd0);

        // Four back-to-back frames with zero idle between them
        lb[0] = 8'h01; lb[1] = 8'h80; lb[2] = 8'hFF; lb[3] = 8'h7E;
        q0 = popped.size(); fe0 = fe_cnt; ovf0 = ovf_cnt;
        for (int i = 0; i < 4; i++) begin
            send_frame(lb[i], 1'b1);
        end
        tick(40);
        chk("b2b_count", popped.size() - q0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_word%0d", i), {24'd0, popped[q0 + i]}, {24'd0, lb[i]});
        end
        chk("b2b_frameError", fe_cnt - fe0,   32'd0);
        chk("b2b_overflow",   ovf_cnt - ovf0, 32'd0);

        // Reset in the middle of 0x99 data bits with a word already buffered
        rxReady = 1'b0;
        send_frame(8'h11, 1'b1);
        tick(20);
        chk("pre_reset_valid", {31'd0, rxValid}, 32'd1);
        fe0 = fe_cnt; ovf0 = ovf_cnt; q0 = popped.size();
        rxIn = 1'b0;            // start bit
        tick(CPB);
        rxIn = 1'b1; tick(CPB); // bit0 of 0x99
        rxIn = 1'b0; tick(CPB); // bit1
        rxIn = 1'b0; tick(CPB / 2); // partway into bit2
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        rxIn  = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_rxValid", {31'd0, rxValid}, 32'd0);
        chk("rst_rxData",  {24'd0, rxData},  32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        rxReady = 1'b1;
        tick(40);
        chk("rst_no_words",   popped.size() - q0, 32'd0);
        chk("rst_frameError", fe_cnt - fe0,       32'd0);
        chk("rst_overflow",   ovf_cnt - ovf0,     32'd0);
        send_frame(8'h42, 1'b1);
        tick(40);
        chk("post_rst_count", popped.size() - q0, 32'd1);
        chk("post_rst_data",  {24'd0, popped[q0]}, 32'h0000_0042);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
